// File: rtl/serial_subtractor4bit.sv
// Bit-serial subtractor computing a - b - bin one bit per clock, LSB first, with a start/done handshake.
// Optional macro SUB_OVERFLOW_EN adds a signed-overflow flag (ovf) reported alongside done.
module serial_subtractor4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    bitCount_q, bitCount_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             aBit, bBit, diffBit, borrowNext, accept;
`ifdef SUB_OVERFLOW_EN
  logic             aMsb_q, aMsb_d, bMsb_q, bMsb_d, ovf_q, ovf_d;
`endif

  assign aBit       = aShift_q[0];
  assign bBit       = bShift_q[0];
  assign diffBit    = aBit ^ bBit ^ borrow_q;
  assign borrowNext = (~aBit & bBit) | (~(aBit ^ bBit) & borrow_q);
  // A new request is only taken while not busy; DONE counts as not busy for back-to-back ops.
  assign accept     = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    result_d   = result_q;
    diff_d     = diff_q;
    bitCount_d = bitCount_q;
    borrow_d   = borrow_q;
    bout_d     = bout_q;
`ifdef SUB_OVERFLOW_EN
    aMsb_d     = aMsb_q;
    bMsb_d     = bMsb_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: state_d = IDLE;
      CALC: begin
        aShift_d   = aShift_q >> 1;
        bShift_d   = bShift_q >> 1;
        result_d   = {diffBit, result_q[WIDTH-1:1]};
        borrow_d   = borrowNext;
        bitCount_d = bitCount_q + CW'(1);
        // The final bit lands straight in the output registers so diff is valid with done.
        if (bitCount_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = {diffBit, result_q[WIDTH-1:1]};
          bout_d  = borrowNext;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = (aMsb_q != bMsb_q) && (diffBit != aMsb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d    = CALC;
      aShift_d   = a;
      bShift_d   = b;
      borrow_d   = bin;
      bitCount_d = '0;
      result_d   = '0;
`ifdef SUB_OVERFLOW_EN
      aMsb_d     = a[WIDTH-1];
      bMsb_d     = b[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      result_q   <= '0;
      diff_q     <= '0;
      bitCount_q <= '0;
      borrow_q   <= 1'b0;
      bout_q     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      aMsb_q     <= 1'b0;
      bMsb_q     <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      result_q   <= result_d;
      diff_q     <= diff_d;
      bitCount_q <= bitCount_d;
      borrow_q   <= borrow_d;
      bout_q     <= bout_d;
`ifdef SUB_OVERFLOW_EN
      aMsb_q     <= aMsb_d;
      bMsb_q     <= bMsb_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule
